// File: rtl/xadc_pkg.sv
// Shared constants, types and FSM states for the XADC DRP responder emulation.
package xadc_pkg;

    localparam int unsigned ADDR_W         = 7;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned SAMPLE_W       = 12;
    localparam int unsigned CH_W           = 5;
    localparam int unsigned SEQ_W          = 4;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned LAT_W          = 4;
    localparam int unsigned CFG0_CH_LSB    = 0;
    localparam int unsigned CFG0_EVENT_BIT = 9;
    localparam int unsigned CFG1_SEQ_LSB   = 12;

    localparam logic [ADDR_W-1:0] ADDR_RESULT_BASE = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_CFG0        = 7'h40;
    localparam logic [ADDR_W-1:0] ADDR_CFG1        = 7'h41;

    localparam logic [SEQ_W-1:0] SEQ_SINGLE = 4'h3;
    localparam logic [SEQ_W-1:0] SEQ_CONT   = 4'h2;

    typedef enum logic [1:0] {IDLE, CONV, DONE} seq_state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } drp_req_t;

endpackage

// File: rtl/xadc_drp_responder_if.sv
// DRP bus between the requesting bridge (master) and the XADC responder (slave).
interface xadc_drp_responder_if;
    import xadc_pkg::*;

    logic [ADDR_W-1:0] DADDR;
    logic              DEN;
    logic              DWE;
    logic [DATA_W-1:0] DI;
    logic [DATA_W-1:0] DO;
    logic              DRDY;

    modport master (output DADDR, DEN, DWE, DI, input DO, DRDY);
    modport slave  (input DADDR, DEN, DWE, DI, output DO, DRDY);
endinterface

// File: rtl/xadc_drp_responder_conv_seq.sv
// Conversion sequencer: IDLE/CONV/DONE FSM, BUSY counter and channel pointer.
module xadc_conv_seq
    import xadc_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CONV_CYCLES = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH_W-1:0]  sel,
    input  logic             event_mode,
    input  logic [SEQ_W-1:0] seq,
    input  logic             convst,
    output logic             busy,
    output logic             eoc,
    output logic             eos,
    output logic [CH_W-1:0]  channel,
    output logic             res_we
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  pos_q, pos_d, cur_pos, channel_d;
    logic [SEQ_W-1:0] seq_q;
    logic             convst_q, last_q, last_d, valid_q, valid_d;
    logic             start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pos_q    <= '0;
            seq_q    <= '0;
            convst_q <= 1'b0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            channel  <= '0;
            busy     <= 1'b0;
            eoc      <= 1'b0;
            eos      <= 1'b0;
            res_we   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            seq_q    <= seq;
            convst_q <= convst;
            last_q   <= last_d;
            valid_q  <= valid_d;
            channel  <= channel_d;
            busy     <= (state_d == CONV);
            eoc      <= (state_d == DONE);
            eos      <= (state_d == DONE) && last_d;
            res_we   <= (state_d == DONE) && valid_d;
        end
    end

    // Any SEQ change rewinds the continuous sequence to channel 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        valid_d   = valid_q;
        channel_d = channel;
        cur_pos   = (seq != seq_q) ? '0 : pos_q;
        pos_d     = cur_pos;
        start     = ((seq == SEQ_SINGLE) || (seq == SEQ_CONT)) &&
                    (event_mode ? (convst && !convst_q) : 1'b1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    cnt_d   = CNT_W'(CONV_CYCLES - 1);
                    if (seq == SEQ_SINGLE) begin
                        channel_d = sel;
                        last_d    = 1'b1;
                    end else begin
                        channel_d = cur_pos;
                        last_d    = (cur_pos == CH_W'(NUM_CH - 1));
                        pos_d     = last_d ? '0 : CH_W'(cur_pos + 1'b1);
                    end
                    valid_d = (channel_d < CH_W'(NUM_CH));
                end
            end
            CONV: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = CNT_W'(cnt_q - 1'b1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC primitive stand-in: DRP front-end and register file around the conversion sequencer.
module xadc_drp_responder
    import xadc_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DRP_LATENCY = 2,
    parameter int unsigned CONV_CYCLES = 26,
    parameter logic [15:0] CFG1_RST    = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    xadc_drp_responder_if.slave          drp,
    input  logic                         CONVST,
    input  logic [NUM_CH*SAMPLE_W-1:0]   sample_in,
    output logic                         BUSY,
    output logic [CH_W-1:0]              CHANNEL,
    output logic                         EOC,
    output logic                         EOS,
    output logic [CH_W-1:0]              MUXADDR,
    output logic                         drp_err
);

    logic [LAT_W-1:0]    lat_q, lat_d;
    drp_req_t            req_q, cur_req;
    logic [DATA_W-1:0]   rdata_q, live_rdata, cur_rdata;
    logic [DATA_W-1:0]   cfg0_q, cfg1_q;
    logic [SAMPLE_W-1:0] result_q [NUM_CH];
    logic                accept, finish, res_we;

    assign MUXADDR = '0;

    // Live read mux; results reflect the value before any same-cycle EOC update.
    always_comb begin
        live_rdata = '0;
        if (drp.DADDR == ADDR_CFG0)      live_rdata = cfg0_q;
        else if (drp.DADDR == ADDR_CFG1) live_rdata = cfg1_q;
        else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (drp.DADDR == ADDR_W'(ADDR_RESULT_BASE + ADDR_W'(n)))
                    live_rdata = {result_q[n], 4'h0};
            end
        end
    end

    // Counter holds DRP_LATENCY..1 while pending; the edge reaching 1 raises DRDY.
    always_comb begin
        accept    = drp.DEN && (lat_q == '0);
        lat_d     = (lat_q != '0) ? LAT_W'(lat_q - 1'b1) : '0;
        if (accept) lat_d = LAT_W'(DRP_LATENCY);
        cur_req   = (lat_q == '0) ? {drp.DWE, drp.DADDR, drp.DI} : req_q;
        cur_rdata = (lat_q == '0) ? live_rdata : rdata_q;
        finish    = (lat_d == LAT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q    <= '0;
            req_q    <= '0;
            rdata_q  <= '0;
            cfg0_q   <= '0;
            cfg1_q   <= CFG1_RST;
            drp.DO   <= '0;
            drp.DRDY <= 1'b0;
            drp_err  <= 1'b0;
        end else begin
            lat_q    <= lat_d;
            drp.DRDY <= finish;
            drp.DO   <= (finish && !cur_req.wr) ? cur_rdata : '0;
            if (drp.DEN && (lat_q != '0)) drp_err <= 1'b1;
            if (accept) begin
                req_q   <= cur_req;
                rdata_q <= live_rdata;
            end
            if (finish && cur_req.wr) begin
                if (cur_req.addr == ADDR_CFG0) cfg0_q <= cur_req.data;
                if (cur_req.addr == ADDR_CFG1) cfg1_q <= cur_req.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_CH; n++) result_q[n] <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (res_we && (CHANNEL == CH_W'(n)))
                    result_q[n] <= sample_in[n*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    xadc_conv_seq #(
        .NUM_CH      (NUM_CH),
        .CONV_CYCLES (CONV_CYCLES)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (cfg0_q[CFG0_CH_LSB +: CH_W]),
        .event_mode (cfg0_q[CFG0_EVENT_BIT]),
        .seq        (cfg1_q[CFG1_SEQ_LSB +: SEQ_W]),
        .convst     (CONVST),
        .busy       (BUSY),
        .eoc        (EOC),
        .eos        (EOS),
        .channel    (CHANNEL),
        .res_we     (res_we)
    );

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Scoreboard bench for xadc_drp_responder: DRP completions and EOC/EOS events checked by a monitor.
module tb_xadc_drp_responder;
    import xadc_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned LAT    = 2;
    localparam int unsigned CONV   = 26;

    logic                   clk    = 1'b0;
    logic                   rst_n  = 1'b0;
    logic                   convst = 1'b0;
    logic [NUM_CH*12-1:0]   sample_in;
    logic                   busy, eoc, eos, drp_err;
    logic [4:0]             channel, muxaddr;

    xadc_drp_responder_if drp();

    xadc_drp_responder #(
        .NUM_CH      (NUM_CH),
        .DRP_LATENCY (LAT),
        .CONV_CYCLES (CONV),
        .CFG1_RST    (16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .drp       (drp),
        .CONVST    (convst),
        .sample_in (sample_in),
        .BUSY      (busy),
        .CHANNEL   (channel),
        .EOC       (eoc),
        .EOS       (eos),
        .MUXADDR   (muxaddr),
        .drp_err   (drp_err)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          eoc_seen = 0;
    int          busy_run = 0;
    int          eoc_cyc_q [$];
    int          exp_cyc_q [$];
    logic [15:0] exp_do_q  [$];
    logic [5:0]  exp_eoc_q [$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents DRDY or EOC.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (drp.DRDY) begin
                if (exp_do_q.size() == 0) check("drdy_unexpected", 32'd1, 32'd0);
                else begin
                    check("drp_do", drp.DO, exp_do_q.pop_front());
                    check("drdy_cycle", cyc, exp_cyc_q.pop_front());
                end
            end else if (drp.DO !== 16'h0) begin
                check("do_zero_without_drdy", drp.DO, 32'h0);
            end
            if (eoc) begin
                eoc_seen++;
                eoc_cyc_q.push_back(cyc);
                if (exp_eoc_q.size() == 0) check("eoc_unexpected", 32'd1, 32'd0);
                else check("eoc_eos_channel", {eos, channel}, exp_eoc_q.pop_front());
                check("busy_low_in_done", busy, 32'd0);
            end else if (eos) begin
                check("eos_without_eoc", 32'd1, 32'd0);
            end
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                check("busy_length", busy_run, CONV);
                busy_run = 0;
            end
        end
    end

    task automatic drp_op(input logic wr, input logic [6:0] a, input logic [15:0] d, input logic [15:0] exp);
        @(posedge clk); #1;
        drp.DEN = 1'b1; drp.DWE = wr; drp.DADDR = a; drp.DI = d;
        exp_do_q.push_back(wr ? 16'h0000 : exp);
        exp_cyc_q.push_back(cyc + LAT);
        @(posedge clk); #1;
        drp.DEN = 1'b0; drp.DWE = 1'b0;
        repeat (LAT + 1) @(posedge clk);
    endtask

    task automatic pulse_convst();
        @(posedge clk); #1 convst = 1'b1;
        @(posedge clk); #1 convst = 1'b0;
    endtask

    task automatic wait_eoc(input int n, input int budget);
        int k = 0;
        while (eoc_seen < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (eoc_seen < n) check("eoc_timeout", eoc_seen, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        drp.DEN = 1'b0; drp.DWE = 1'b0; drp.DADDR = '0; drp.DI = '0;
        sample_in = {12'h789, 12'h456, 12'hABC, 12'h123};

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_do", drp.DO, 32'h0);
        check("rst_drdy", drp.DRDY, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_eoc", eoc, 32'h0);
        check("rst_eos", eos, 32'h0);
        check("rst_channel", channel, 32'h0);
        check("rst_muxaddr", muxaddr, 32'h0);
        check("rst_drp_err", drp_err, 32'h0);
        rst_n = 1'b1;

        // Read CFG1 reset value; sequencer stays idle
        drp_op(1'b0, 7'h41, 16'h0, 16'h0000);
        repeat (5) @(posedge clk);
        check("idle_no_busy", busy, 32'h0);

        // Single-channel, event mode, channel 1
        drp_op(1'b1, 7'h40, 16'h0201, 16'h0);
        drp_op(1'b1, 7'h41, 16'h3000, 16'h0);
        exp_eoc_q.push_back({1'b1, 5'd1});
        pulse_convst();
        wait_eoc(1, 60);
        repeat (2) @(posedge clk);
        drp_op(1'b0, 7'h01, 16'h0, 16'hABC0);

        // CONVST edges during BUSY are ignored
        exp_eoc_q.push_back({1'b1, 5'd1});
        pulse_convst();
        repeat (5) @(posedge clk);
        pulse_convst();
        repeat (5) @(posedge clk);
        pulse_convst();
        wait_eoc(2, 80);
        repeat (40) @(posedge clk);
        check("convst_busy_ignored", eoc_seen, 32'd2);

        // Out-of-range single channel: EOC/EOS with CHANNEL=5, nothing stored
        drp_op(1'b1, 7'h40, 16'h0205, 16'h0);
        exp_eoc_q.push_back({1'b1, 5'd5});
        pulse_convst();
        wait_eoc(3, 60);
        repeat (2) @(posedge clk);
        drp_op(1'b0, 7'h05, 16'h0, 16'h0000);
        drp_op(1'b0, 7'h01, 16'h0, 16'hABC0);
        drp_op(1'b0, 7'h10, 16'h0, 16'h0000);
        drp_op(1'b0, 7'h40, 16'h0, 16'h0205);
        drp_op(1'b0, 7'h41, 16'h0, 16'h3000);

        // Continuous sequence 0,1,2,3,0,1 then stop mid-conversion
        drp_op(1'b1, 7'h41, 16'h2000, 16'h0);
        exp_eoc_q.push_back({1'b0, 5'd0});
        exp_eoc_q.push_back({1'b0, 5'd1});
        exp_eoc_q.push_back({1'b0, 5'd2});
        exp_eoc_q.push_back({1'b1, 5'd3});
        exp_eoc_q.push_back({1'b0, 5'd0});
        exp_eoc_q.push_back({1'b0, 5'd1});
        drp_op(1'b1, 7'h40, 16'h0000, 16'h0);
        wait_eoc(8, 200);
        repeat (5) @(posedge clk);
        drp_op(1'b1, 7'h41, 16'h0000, 16'h0);
        wait_eoc(9, 60);
        repeat (40) @(posedge clk);
        check("continuous_stopped", eoc_seen, 32'd9);
        if (eoc_cyc_q.size() >= 9) begin
            for (int i = 4; i < 9; i++)
                check("eoc_spacing", eoc_cyc_q[i] - eoc_cyc_q[i-1], CONV + 2);
        end
        drp_op(1'b0, 7'h00, 16'h0, 16'h1230);
        drp_op(1'b0, 7'h02, 16'h0, 16'h4560);
        drp_op(1'b0, 7'h03, 16'h0, 16'h7890);
        drp_op(1'b1, 7'h00, 16'hFFFF, 16'h0);
        drp_op(1'b1, 7'h55, 16'hFFFF, 16'h0);
        drp_op(1'b0, 7'h00, 16'h0, 16'h1230);

        // Back-to-back DEN: single DRDY, sticky drp_err
        @(posedge clk); #1;
        drp.DEN = 1'b1; drp.DWE = 1'b0; drp.DADDR = 7'h41;
        exp_do_q.push_back(16'h0000);
        exp_cyc_q.push_back(cyc + LAT);
        @(posedge clk); #1;
        drp.DADDR = 7'h40;
        @(posedge clk); #1;
        drp.DEN = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("drp_err_set", drp_err, 32'h1);
        repeat (10) @(posedge clk); #1;
        check("drp_err_sticky", drp_err, 32'h1);

        // Reset mid-conversion and mid-DRP
        drp_op(1'b1, 7'h41, 16'h2000, 16'h0);
        repeat (10) @(posedge clk); #1;
        drp.DEN = 1'b1; drp.DWE = 1'b0; drp.DADDR = 7'h40;
        @(posedge clk); #1;
        drp.DEN = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_drdy", drp.DRDY, 32'h0);
        check("abort_do", drp.DO, 32'h0);
        check("abort_busy", busy, 32'h0);
        check("abort_eoc", eoc, 32'h0);
        check("abort_eos", eos, 32'h0);
        check("abort_channel", channel, 32'h0);
        check("abort_drp_err", drp_err, 32'h0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk); #1;
        check("post_abort_busy", busy, 32'h0);
        check("post_abort_no_eoc", eoc_seen, 32'd9);
        check("drp_queue_drained", exp_do_q.size(), 32'd0);
        check("eoc_queue_drained", exp_eoc_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xadc_drp_responder.md
Name: xadc_drp_responder

Overview:
- Synthesizable responder-side emulation of the 7-series XADC dynamic reconfiguration port (DRP) and its conversion sequencer.
- It answers the DRP transactions issued by xadc_interface and produces BUSY/CHANNEL/EOC/EOS/MUXADDR from digital sample inputs.
- The bridge can therefore be exercised on boards or benches without the hard XADC macro.
- It drops in at the top level in place of the XADC primitive, port-for-port on the DRP and status side.

Parameters:
- NUM_CH, 4, number of emulated channels (0..NUM_CH-1), range 1..16.
- DRP_LATENCY, 2, cycles from accepted DEN to DRDY, range 1..15.
- CONV_CYCLES, 26, BUSY duration per conversion, range 2..255.
- CFG1_RST, 16'h0000, reset value of CFG1 (sequencer off).

Ports:
- clk  in  1  DRP and conversion clock (DCLK domain).
- rst_n  in  1  asynchronous active-low reset.
- DADDR  in  7  DRP address.
- DEN  in  1  DRP enable, single-cycle request strobe.
- DWE  in  1  DRP write enable, qualified by DEN.
- DI  in  16  DRP write data.
- DO  out  16  DRP read data, valid only with DRDY.
- DRDY  out  1  DRP completion pulse.
- CONVST  in  1  event-mode conversion start (rising edge).
- sample_in  in  NUM_CH*12  12-bit sample per channel; channel n is at [n*12+11:n*12].
- BUSY  out  1  conversion in progress.
- CHANNEL  out  5  channel of current/last conversion.
- EOC  out  1  end-of-conversion pulse.
- EOS  out  1  end-of-sequence pulse.
- MUXADDR  out  5  external mux address; constant 0.
- drp_err  out  1  sticky: DEN received while a transaction was pending.

Behaviour:
- Reset (async assert, sync deassert internal use):
  - Outputs: DO=0, DRDY=0, BUSY=0, EOC=0, EOS=0, CHANNEL=0, MUXADDR=0, drp_err=0.
  - Registers: CFG0=0, CFG1=CFG1_RST, all result regs 0.
  - Reset mid-operation aborts any DRP transaction or conversion immediately; no DRDY or EOC is emitted afterwards.
- DRP accept:
  - DEN is accepted only when no transaction is pending.
  - Read data and write data are captured in the DEN cycle.
  - DRDY pulses high for exactly 1 cycle, DRP_LATENCY cycles after DEN.
  - DO carries the captured data in the DRDY cycle and is 0 otherwise.
- DEN while pending: the request is ignored, drp_err is set, and the pending transaction completes normally. drp_err clears only on reset.
- Writes commit in the DRDY cycle. A write returns DO=0.
- Register map:
  - 7'h00+n (n<NUM_CH): result, read-only = {sample_n[11:0],4'h0} latched at the channel's last EOC.
  - 7'h40: CFG0; [4:0] single-channel select, [9] event mode.
  - 7'h41: CFG1; [15:12] SEQ.
  - Writes to result or unmapped addresses are ignored. Reads of unmapped addresses and results for n>=NUM_CH return 0.
- Read/conversion collision: a DRP read of a result register in the same cycle that an EOC updates it returns the old value.
- Sequencer modes:
  - SEQ=4'h3: single channel, converts CFG0[4:0].
  - SEQ=4'h2: continuous, converts 0..NUM_CH-1 in order, then wraps to 0.
  - Any other SEQ value: idle, no conversions.
- Sequencer FSM:
  - IDLE -> CONV on start. Start is either the CONVST rising edge (event mode) or the first cycle in IDLE with an active SEQ (continuous).
  - CONV: BUSY=1 for CONV_CYCLES cycles; CHANNEL is updated on entry.
  - CONV -> DONE. DONE lasts 1 cycle: EOC=1, result register written.
  - EOS=1 in the same DONE cycle when the converted channel is the last of the sequence. In single-channel mode EOS accompanies every EOC.
  - DONE -> IDLE.
- Consecutive conversions: in continuous mode they are spaced CONV_CYCLES+2 cycles apart.
- CONVST edges: ignored while BUSY or in DONE; only rising edges in IDLE are counted.
- Single-channel select out of range: CFG0[4:0]>=NUM_CH converts and stores nothing but still produces EOC/EOS with CHANNEL=CFG0[4:0].
- Config writes during CONV: the current conversion finishes unchanged. New CFG0/CFG1 take effect at the next IDLE -> CONV. A SEQ change restarts sequence position at channel 0.

Decomposition:
- Shared package xadc_pkg holds:
  - DRP address constants (ADDR_RESULT_BASE, ADDR_CFG0, ADDR_CFG1).
  - SEQ encodings (SEQ_SINGLE=3, SEQ_CONT=2).
  - CFG0 field positions.
  - FSM state enum {IDLE, CONV, DONE}.
- One sub-module, xadc_conv_seq, contains the sequencer FSM, conversion counter and channel pointer. It takes CFG0/CFG1 and exports BUSY/EOC/EOS/CHANNEL plus a result write strobe.
- The DRP front-end and register file stay in the top module.

Test Plan:
- Reset then DRP read 7'h41 -> DRDY exactly 2 cycles after DEN, DO=16'h0000; no BUSY activity.
- Write CFG0=16'h0001 then CFG1=16'h3000, sample_in ch1=12'hABC -> BUSY high 26 cycles; EOC and EOS pulse together with CHANNEL=1; read 7'h01 returns 16'hABC0.
- CFG1=16'h2000, NUM_CH=4 -> EOC on channels 0,1,2,3,0 spaced 28 cycles apart; EOS only with channel 3; wrap to 0 verified.
- CFG0[9]=1, SEQ=3, CONVST pulsed twice during BUSY and once in IDLE -> exactly one conversion per IDLE edge, edges during BUSY are ignored.
- Issue DEN at cycle t and again at t+1 -> single DRDY at t+2, drp_err=1 held until rst_n low.
- Deassert rst_n at mid-CONV and mid-DRP -> all outputs 0 within the same cycle; no EOC or DRDY after release.
